// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/EXEC control of instruction fetch,
// redirect selection (trap > mret > jump > branch > sequential) and retire count.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  output logic        o_instr_valid,
  input  logic        i_exec_done,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_trap_req,
  input  logic        i_mret,
  output logic [31:0] o_pc,
  output logic [31:0] o_epc,
  output logic [31:0] o_retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [31:0] r_retired;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic [31:0] w_pc_next;
  logic [31:0] w_epc_next;
  logic [31:0] w_retired_next;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_complete;

  assign w_complete = (r_state == S_EXEC) && i_exec_done && !i_stall;
  assign w_redirect = i_jump || i_branch_taken;
  assign w_target   = i_jump ? i_jump_target : i_branch_target;

  // Next-state and architectural-state update selection
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_epc_next     = r_epc;
    w_retired_next = r_retired;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          w_state_next = S_EXEC;
        end else begin
          w_state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        if (w_complete) begin
          w_state_next = S_FETCH;
          if (i_trap_req) begin
            w_pc_next  = TRAP_VECTOR;
            w_epc_next = r_pc;
          end else if (i_mret) begin
            w_pc_next      = r_epc;
            w_retired_next = r_retired + 32'd1;
          end else if (w_redirect && (w_target[1:0] != 2'b00)) begin
            // misaligned control-flow target is promoted to a trap
            w_pc_next  = TRAP_VECTOR;
            w_epc_next = r_pc;
          end else if (w_redirect) begin
            w_pc_next      = w_target;
            w_retired_next = r_retired + 32'd1;
          end else begin
            w_pc_next      = r_pc + 32'd4;
            w_retired_next = r_retired + 32'd1;
          end
        end else begin
          w_state_next = S_EXEC;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, architectural registers and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_VECTOR;
      r_epc         <= 32'h0000_0000;
      r_retired     <= 32'h0000_0000;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_epc         <= w_epc_next;
      r_retired     <= w_retired_next;
      r_imem_req    <= (w_state_next == S_FETCH);
      r_instr_valid <= (w_state_next == S_EXEC);
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_pc          = r_pc;
  assign o_epc         = r_epc;
  assign o_retired     = r_retired;

endmodule
